// File: rtl/prio_encoder_stream_pkg.sv
// Shared constants and types for the streaming priority encoder.
// Build option: PRIO_ENCODER_ROUND_ROBIN_EN selects round-robin instead of highest-index-first.
package prio_encoder_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = $clog2(N_DEFAULT);

    localparam int                   DUP_CNT_W   = 8;
    localparam logic [DUP_CNT_W-1:0] DUP_CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/prio_encoder_stream_if.sv
// Request/handshake bundle between request sources, the encoder and its consumer.
interface prio_encoder_stream_if
    import prio_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = $clog2(N)
);

    logic                 en;
    logic [N-1:0]         bcode;
    logic [W-1:0]         a;
    logic                 valid;
    logic                 ready;
    logic [N-1:0]         pend;
    logic [DUP_CNT_W-1:0] dup_cnt;

    // The master is the environment (sources plus consumer); the encoder is the slave.
    modport master (
        output en, bcode, ready,
        input  a, valid, pend, dup_cnt
    );

    modport slave (
        input  en, bcode, ready,
        output a, valid, pend, dup_cnt
    );

endinterface

// File: rtl/prio_encoder_stream_pick.sv
// Combinational find-first-set over N request bits, searching from a rotation offset.
// DESCEND=1 searches N-1 down to 0 and ignores the offset.
module prio_pick #(
    parameter int N       = 4,
    parameter int W       = $clog2(N),
    parameter bit DESCEND = 1'b1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] offset,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // W-bit addition wraps modulo N because N is a power of two.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int j = 0; j < N; j++) begin
            cand = DESCEND ? W'(N - 1 - j) : offset + W'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_stream.sv
// Sticky request capture plus a one-entry valid/ready output stage issuing encoded indices.
// Build option: PRIO_ENCODER_ROUND_ROBIN_EN adds a rotating search pointer.
module prio_encoder_stream
    import prio_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = $clog2(N)
) (
    input logic                  clk,
    input logic                  rst_n,
    prio_encoder_stream_if.slave bus
);

    out_state_t           state_q, state_d;
    logic [N-1:0]         pend_q, pend_d;
    logic [N-1:0]         clr_mask, set_mask;
    logic [W-1:0]         a_q, a_d;
    logic [DUP_CNT_W-1:0] dup_q, dup_d;
    logic                 dup_hit;
    logic                 load;
    logic                 pick_found;
    logic [W-1:0]         pick_idx;
    logic [W-1:0]         offset;

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
    localparam bit DESCEND = 1'b0;
    logic [W-1:0] ptr_q, ptr_d;
    assign offset = ptr_q;
    assign ptr_d  = load ? pick_idx + W'(1) : ptr_q;
`else
    localparam bit DESCEND = 1'b1;
    assign offset = '0;
`endif

    prio_pick #(
        .N       (N),
        .W       (W),
        .DESCEND (DESCEND)
    ) u_pick (
        .req    (pend_q),
        .offset (offset),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        load     = 1'b0;
        clr_mask = '0;

        case (state_q)
            EMPTY: load = pick_found;
            FULL: begin
                if (bus.ready) begin
                    load = pick_found;
                    if (!pick_found) state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (load) begin
            state_d  = FULL;
            a_d      = pick_idx;
            clr_mask = {{(N-1){1'b0}}, 1'b1} << pick_idx;
        end

        // Set after clear, so a new request on the bit being issued survives.
        set_mask = bus.en ? bus.bcode : '0;
        pend_d   = (pend_q & ~clr_mask) | set_mask;
        dup_hit  = |(set_mask & pend_q & ~clr_mask);
        dup_d    = (dup_hit && dup_q != DUP_CNT_MAX) ? dup_q + DUP_CNT_W'(1) : dup_q;
    end

    // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pend_q  <= '0;
            a_q     <= '0;
            dup_q   <= '0;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            dup_q   <= dup_d;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.a       = a_q;
    assign bus.valid   = (state_q == FULL);
    assign bus.pend    = pend_q;
    assign bus.dup_cnt = dup_q;

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Directed-vector bench for prio_encoder_stream; expected values are hand-computed per step.
module tb_prio_encoder_stream;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    prio_encoder_stream_if #(.N(4)) bus ();

    prio_encoder_stream #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.bcode = '0;
        bus.ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Expected issue order for bcode=4'b1011 in each build.
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
    localparam logic [1:0] ORD0 = 2'd0, ORD1 = 2'd1, ORD2 = 2'd3;
    localparam logic [3:0] PEND_AFTER_FIRST = 4'b1010;
`else
    localparam logic [1:0] ORD0 = 2'd3, ORD1 = 2'd1, ORD2 = 2'd0;
    localparam logic [3:0] PEND_AFTER_FIRST = 4'b0011;
`endif

    initial begin
        rst_n     = 1'b1;
        bus.en    = 1'b0;
        bus.bcode = '0;
        bus.ready = 1'b0;

        // Reset held two edges while requests are present.
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.bcode = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_pend",  bus.pend,    0);
            check("rst_valid", bus.valid,   0);
            check("rst_a",     bus.a,       0);
            check("rst_dup",   bus.dup_cnt, 0);
        end

        // Single request.
        do_reset();
        bus.en    = 1'b1;
        bus.ready = 1'b1;
        bus.bcode = 4'b0100;
        tick();
        check("single_pend1",  bus.pend,  4'b0100);
        check("single_valid1", bus.valid, 0);
        bus.bcode = 4'b0000;
        tick();
        check("single_valid2", bus.valid, 1);
        check("single_a2",     bus.a,     2);
        check("single_pend2",  bus.pend,  0);
        tick();
        check("single_valid3", bus.valid, 0);
        check("single_a3",     bus.a,     2);

        // Burst order with a three-cycle stall.
        do_reset();
        bus.en    = 1'b1;
        bus.bcode = 4'b1011;
        tick();
        check("burst_pend1", bus.pend, 4'b1011);
        bus.bcode = 4'b0000;
        tick();
        check("burst_valid2", bus.valid, 1);
        check("burst_a2",     bus.a,     ORD0);
        check("burst_pend2",  bus.pend,  PEND_AFTER_FIRST);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("burst_stall_valid", bus.valid, 1);
            check("burst_stall_a",     bus.a,     ORD0);
        end
        bus.ready = 1'b1;
        tick();
        check("burst_a5", bus.a, ORD1);
        tick();
        check("burst_a6",     bus.a,     ORD2);
        check("burst_valid6", bus.valid, 1);
        tick();
        check("burst_valid7", bus.valid, 0);
        check("burst_a7",     bus.a,     ORD2);
        check("burst_pend7",  bus.pend,  0);

        // Enable gate.
        do_reset();
        bus.en    = 1'b0;
        bus.bcode = 4'b1111;
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gate_pend",  bus.pend,    0);
            check("gate_valid", bus.valid,   0);
            check("gate_dup",   bus.dup_cnt, 0);
        end

        // Collision (set wins) and duplicate counting with saturation.
        do_reset();
        bus.en    = 1'b1;
        bus.ready = 1'b0;
        bus.bcode = 4'b0001;
        tick();
        check("coll_pend1", bus.pend,    4'b0001);
        check("coll_dup1",  bus.dup_cnt, 0);
        tick();
        check("coll_valid2", bus.valid,   1);
        check("coll_a2",     bus.a,       0);
        check("coll_pend2",  bus.pend,    4'b0001);
        check("coll_dup2",   bus.dup_cnt, 0);
        tick();
        check("coll_dup3", bus.dup_cnt, 1);
        tick();
        check("coll_dup4", bus.dup_cnt, 2);
        for (int i = 0; i < 252; i++) tick();
        check("sat_dup_254", bus.dup_cnt, 254);
        tick();
        check("sat_dup_255", bus.dup_cnt, 255);
        for (int i = 0; i < 7; i++) tick();
        check("sat_dup_hold", bus.dup_cnt, 255);
        check("sat_valid",    bus.valid,   1);
        check("sat_a",        bus.a,       0);

        // Reset in the middle of activity.
        do_reset();
        bus.en    = 1'b1;
        bus.ready = 1'b0;
        bus.bcode = 4'b1000;
        tick();
        bus.bcode = 4'b1010;
        tick();
        bus.bcode = 4'b0000;
        check("mid_valid_pre", bus.valid, 1);
        check("mid_a_pre",     bus.a,     3);
        check("mid_pend_pre",  bus.pend,  4'b1010);
        rst_n     = 1'b0;
        bus.bcode = 4'b0001;
        tick();
        check("mid_rst_valid", bus.valid,   0);
        check("mid_rst_a",     bus.a,       0);
        check("mid_rst_pend",  bus.pend,    0);
        check("mid_rst_dup",   bus.dup_cnt, 0);
        rst_n     = 1'b1;
        bus.ready = 1'b1;
        bus.bcode = 4'b0010;
        tick();
        bus.bcode = 4'b0000;
        check("mid_new_pend", bus.pend, 4'b0010);
        tick();
        check("mid_new_valid", bus.valid, 1);
        check("mid_new_a",     bus.a,     1);
        tick();
        check("mid_new_drain", bus.valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
